// File: rtl/fsm_rsp_pkg.sv
// Shared state encodings for the read-handshake responder and its bench.
package fsm_rsp_pkg;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_PH2  = 2'd1,
    RSP_PH1  = 2'd2,
    RSP_DATA = 2'd3
  } rsp_state_e;

endpackage

// File: rtl/fsm_rsp_wcnt.sv
// Loadable down-counter holding the remaining wait states of a read.
module fsm_rsp_wcnt #(
  parameter int WW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [WW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [WW-1:0] cnt_q, cnt_d;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/fsm_rd_responder.sv
// Target-side read responder: wait-state insertion and register-array read data.
// Optional protocol checker on `err` enabled by FSM_RSP_PROTO_CHECK_EN.
module fsm_rd_responder
  import fsm_rsp_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 8,
  parameter int WW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd,
  input  logic          ds,
  input  logic [AW-1:0] addr,
  input  logic [WW-1:0] wait_cfg,
  output logic          ws,
  output logic [DW-1:0] rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  output logic          err
);

  localparam int DEPTH = 2**AW;

  rsp_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          cnt_load, cnt_dec, cnt_zero;

  fsm_rsp_wcnt #(.WW(WW)) u_wcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (wait_cfg),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Moore decode: async reset forces IDLE, so ws drops in the reset cycle.
  assign ws = (state_q == RSP_PH2) && !cnt_zero;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      RSP_IDLE: begin
        if (rd) begin
          addr_d   = addr;
          cnt_load = 1'b1;
          state_d  = RSP_PH2;
        end
      end
      RSP_PH2: begin
        if (!rd) begin
          state_d = RSP_IDLE;
        end else if (ws) begin
          cnt_dec = 1'b1;
          state_d = RSP_PH1;
        end else begin
          rdata_d = mem_q[addr_q];
          state_d = RSP_DATA;
        end
      end
      RSP_PH1:  state_d = rd ? RSP_PH2 : RSP_IDLE;
      RSP_DATA: state_d = RSP_IDLE;
      default:  state_d = RSP_IDLE;
    endcase
  end

`ifdef FSM_RSP_PROTO_CHECK_EN
  logic proto_viol;
  always_comb begin
    proto_viol = (ds != (state_q == RSP_DATA));
    if (((state_q == RSP_PH1) || (state_q == RSP_PH2)) && !rd) begin
      proto_viol = 1'b1;
    end
  end
  assign err_d = err_q | proto_viol;
`else
  logic unused_ds;
  assign unused_ds = ds;
  assign err_d     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RSP_IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the array must read back as zero after reset, so each word is a resettable flop rather than an inferred RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = rdata_q;
  assign err   = err_q;

endmodule
